dcache_2way_wb: RTL
===================

// Module: dcache_2way_wb
// PURPOSE
//  2-way set-associative, write-back, write-allocate data cache between the pipelined datapath MEM stage and 64-bit line memory.
//  Datapath side is word-wide (16b) with a ready handshake; memory side moves whole 4-word lines with a fixed-latency readM/writeM protocol.
//  Replaces the direct-mapped data cache; adds hit/miss counters for performance reporting alongside num_inst.
// PARAMETERS
//  WORD_SIZE    16  datapath word width (bits)
//  NUM_SETS     4   sets; power of 2, >=2; index = addr[2+log2(NUM_SETS)-1:2]
//  MEM_LATENCY  2   cycles a readM/writeM must be held before memory completes (>=1)
// PORTS
//  clk            in   1    clock, rising edge
//  reset_n        in   1    asynchronous active-low reset
//  read_cache     in   1    datapath load request (held until ready)
//  write_cache    in   1    datapath store request (held until ready)
//  address_cache  in   16   word address of request
//  wdata          in   16   store data
//  rdata          out  16   load data, valid when ready && read_cache
//  ready          out  1    request completes this cycle
//  address_memory out  16   line base address {tag,index,2'b00}
//  readM          out  1    memory line read
//  writeM         out  1    memory line write
//  data_mem       inout 64  line data; driven by cache only while writeM=1, else Z
//  hit_count      out  16   accepted requests that hit on first lookup (wraps)
//  miss_count     out  16   misses (wraps)
// BEHAVIOUR
//  Address split: offset=addr[1:0] (word 0 in data_mem[15:0] ... word 3 in [63:48]), index above it, tag = remaining upper bits.
//  Per set per way: valid, dirty, tag, 4x16b data; per set: lru bit (way to evict next).
//  Reset (async): all valid/dirty/lru=0, counters=0, state=IDLE, ready=0, readM=writeM=0, rdata=0, address_memory=0, data_mem=Z. Reset mid-miss aborts the transfer.
//  FSM: IDLE, WB, FILL.
//  IDLE: request = read_cache|write_cache. Hit (valid && tag match in either way) -> ready=1 combinationally same cycle;
//    load: rdata=selected word; store: word written and dirty=1 at the edge; lru set to other way; hit_count+1 unless the request was the replay after a miss.
//  IDLE miss: ready=0; miss_count+1; victim = first invalid way (way0 first), else way lru. Victim valid&&dirty -> WB, else -> FILL.
//  WB: writeM=1, address_memory=victim line base, data_mem=victim line, held MEM_LATENCY cycles; then dirty=0, -> FILL.
//  FILL: readM=1, address_memory=requested line base, held MEM_LATENCY cycles; on last cycle's edge capture data_mem into victim way, valid=1, dirty=0, tag set; -> IDLE.
//  Replay: back in IDLE request now hits, completes with ready=1 (store merges then, dirty=1). Not counted as a hit.
//  Latency: hit 0 extra cycles; clean miss MEM_LATENCY+1; dirty miss 2*MEM_LATENCY+1.
//  readM and writeM never both 1; ready never 1 outside IDLE.
//  read_cache && write_cache both 1: treated as store.
//  Request dropped during WB/FILL: transfer completes, line installed, no store merge, no counter change.
//  Address change during miss: ignored until IDLE; then new address looked up fresh.
//  Counters wrap 16'hFFFF -> 0.
// TESTING
//  Read 0x0010 after reset (MEM_LATENCY=2, mem line=0x0004_0003_0002_0001) -> readM 2 cycles @0x0010, ready on cycle 3, rdata=0x0001, miss_count=1.
//  Then read 0x0013 -> ready same cycle, rdata=0x0004, no readM, hit_count=1.
//  Write 0x0011=0xBEEF, fill 0x0050 and 0x0090 (same set 0): first two land in ways 0/1; third evicts way0 (lru)
//    -> writeM 2 cycles @0x0010 with data_mem[31:16]=0xBEEF, then readM @0x0090; total 5 cycles.
//  Hit alternating ways of set 1 -> lru flips each access; victim on next miss = least recently used way.
//  Drop read_cache in 1st FILL cycle -> fill completes, ready stays 0, later read of same line hits.
//  Assert reset_n=0 during WB -> writeM, readM drop immediately; after release all reads miss, counters=0.

Source files
------------

// File: rtl/dcache_2way_wb_if.sv
// Datapath request/response and memory-line control signals of the 2-way write-back data cache.
// The 64-bit data_mem line bus is a plain inout port on the cache.
interface dcache_2way_wb_if #(
  parameter int WORD_SIZE = 16
);
  logic                 read_cache;
  logic                 write_cache;
  logic [15:0]          address_cache;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic                 ready;
  logic [15:0]          address_memory;
  logic                 readM;
  logic                 writeM;

  modport master (
    output read_cache, write_cache, address_cache, wdata,
    input  rdata, ready, address_memory, readM, writeM
  );

  modport slave (
    input  read_cache, write_cache, address_cache, wdata,
    output rdata, ready, address_memory, readM, writeM
  );
endinterface

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU.
// Word-wide datapath side, whole 4-word lines on the fixed-latency memory side.
module dcache_2way_wb #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_SETS    = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dcache_2way_wb_if.slave        bus,
  inout  wire  [4*WORD_SIZE-1:0] data_mem,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 16 - 2 - IDX_W;
  localparam int LINE_W = 4 * WORD_SIZE;
  localparam int CNT_W  = $clog2(MEM_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t state, state_n;

  logic [1:0][NUM_SETS-1:0]            valid_q, dirty_q;
  logic [1:0][NUM_SETS-1:0][TAG_W-1:0] tag_q;
  logic [NUM_SETS-1:0]                 lru_q;
  logic [LINE_W-1:0]                   line_q [2][NUM_SETS];

  logic [CNT_W-1:0] cnt_q;
  logic             vic_q;
  logic [TAG_W-1:0] mtag_q;
  logic [IDX_W-1:0] midx_q;
  logic             replay_q;

  logic             req, hit0, hit1, hit, hit_way, vic, last;
  logic             do_hit, do_miss, ready, read_m, write_m;
  logic [15:0]      addr_mem;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off     = bus.address_cache[1:0];
  assign idx     = bus.address_cache[2 +: IDX_W];
  assign tag     = bus.address_cache[15 -: TAG_W];
  assign req     = bus.read_cache | bus.write_cache;
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;
  // Prefer an empty way (way0 first) before evicting the LRU way.
  assign vic     = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign last    = (cnt_q == CNT_W'(MEM_LATENCY - 1));

  assign bus.ready          = ready;
  assign bus.readM          = read_m;
  assign bus.writeM         = write_m;
  assign bus.address_memory = addr_mem;
  assign bus.rdata          = (do_hit && bus.read_cache) ?
                              line_q[hit_way][idx][int'(off)*WORD_SIZE +: WORD_SIZE] : '0;
  assign data_mem           = write_m ? line_q[vic_q][midx_q] : 'z;

  always_comb begin
    state_n  = state;
    ready    = 1'b0;
    read_m   = 1'b0;
    write_m  = 1'b0;
    addr_mem = '0;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            ready  = 1'b1;
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_n = (valid_q[vic][idx] && dirty_q[vic][idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        write_m  = 1'b1;
        addr_mem = {tag_q[vic_q][midx_q], midx_q, 2'b00};
        if (last) state_n = FILL;
      end
      FILL: begin
        read_m   = 1'b1;
        addr_mem = {mtag_q, midx_q, 2'b00};
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt_q      <= '0;
      vic_q      <= 1'b0;
      mtag_q     <= '0;
      midx_q     <= '0;
      replay_q   <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '0;
      lru_q      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_n;
      cnt_q <= (state != IDLE && !last) ? cnt_q + 1'b1 : '0;
      if (state == IDLE) replay_q <= 1'b0;
      if (do_hit) begin
        lru_q[idx] <= ~hit_way;
        if (bus.write_cache) dirty_q[hit_way][idx] <= 1'b1;
        if (!replay_q) hit_count <= hit_count + 16'd1;
      end
      if (do_miss) begin
        miss_count <= miss_count + 16'd1;
        vic_q      <= vic;
        mtag_q     <= tag;
        midx_q     <= idx;
      end
      if (state == WB && last) dirty_q[vic_q][midx_q] <= 1'b0;
      // A request still held when the fill lands is the replay and must not count as a hit.
      if (state == FILL && last) begin
        valid_q[vic_q][midx_q] <= 1'b1;
        dirty_q[vic_q][midx_q] <= 1'b0;
        tag_q[vic_q][midx_q]   <= mtag_q;
        replay_q               <= req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_hit && bus.write_cache)
      line_q[hit_way][idx][int'(off)*WORD_SIZE +: WORD_SIZE] <= bus.wdata;
    if (state == FILL && last)
      line_q[vic_q][midx_q] <= data_mem;
  end
endmodule
